// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter onto one FIFO write port; ARB_STATS_EN adds per-requester accept counters
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
`ifdef ARB_STATS_EN
  ,
  input  logic                          stat_clr,
  output logic [NUM_REQ*16-1:0]         stat_words
`endif
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST) + 1;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nxt;
  logic [GW-1:0] pick;
  logic [BW-1:0] burst_cnt;
  logic accept;
  function automatic logic [GW-1:0] wrap(input int v);
    return GW'(v % NUM_REQ);
  endfunction
  // search upward from the slot after the previous winner; lowest offset wins
  always_comb begin
    pick = grant_id;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req_valid[wrap(int'(grant_id) + k)]) pick = wrap(int'(grant_id) + k);
  end
  // zero-latency handshake and write-port mux for the granted requester
  always_comb begin
    req_ready = '0;
    req_ready[grant_id] = (state == GRANT) && !fifo_full;
    accept = req_ready[grant_id] && req_valid[grant_id];
    fifo_wr_en = accept;
    fifo_wr_data = accept ? req_data[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
    busy = state == GRANT;
  end
  // grant ends on the last word of a burst or when the owner idles with space available
  always_comb begin
    state_nxt = state == IDLE ? (|req_valid ? GRANT : IDLE)
              : (((accept && burst_cnt == BW'(MAX_BURST - 1)) || (!req_valid[grant_id] && !fifo_full)) ? IDLE : GRANT);
  end
  // state, winner and burst length registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant_id <= GW'(NUM_REQ - 1);
      burst_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |req_valid) begin
        grant_id <= pick;
        burst_cnt <= '0;
      end else if (accept) burst_cnt <= burst_cnt + 1'b1;
    end
  end
`ifdef ARB_STATS_EN
  // saturating accepted-word counters; clear wins over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stat_words <= '0;
    else
      for (int i = 0; i < NUM_REQ; i++)
        if (stat_clr) stat_words[i*16 +: 16] <= '0;
        else if (req_ready[i] && req_valid[i] && stat_words[i*16 +: 16] != 16'hFFFF)
          stat_words[i*16 +: 16] <= stat_words[i*16 +: 16] + 16'd1;
  end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized and directed checks of fifo_wr_arbiter against a transaction-level model
module tb_fifo_wr_arbiter;
  localparam int N = 4, DW = 8, MB = 4;
  logic clk = 0, rst = 0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*DW-1:0] req_data = '0;
  logic fifo_full = 0, fifo_wr_en, busy;
  logic [DW-1:0] fifo_wr_data;
  logic [1:0] grant_id;
`ifdef ARB_STATS_EN
  logic stat_clr = 0;
  logic [N*16-1:0] stat_words;
`endif
  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .grant_id(grant_id), .busy(busy)
`ifdef ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_words(stat_words)
`endif
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0, pct = 100;
  bit v [N];
  logic [7:0] q [N][$];
  bit m_busy;
  int m_last, m_budget;
  bit wpat[$], prev_busy;
  logic [7:0] wlog[$];
  logic [N-1:0] rpat[$];
  int glog[$];
  task automatic clear_logs();
    wpat.delete(); wlog.delete(); rpat.delete(); glog.delete(); prev_busy = 0;
  endtask
  task automatic do_reset();
    rst = 1; req_valid = '0; fifo_full = 0;
    for (int i = 0; i < N; i++) begin v[i] = 0; q[i].delete(); end
    @(posedge clk); #1; rst = 0;
    m_busy = 0; m_last = N - 1; m_budget = 0;
    clear_logs();
  endtask
  // one clock: drive producers, compare against the model at the falling edge, advance the model
  task automatic cycle(input bit full_in);
    logic [N-1:0] vv, er;
    logic [7:0] ed;
    bit acc;
    int w;
    for (int i = 0; i < N; i++) begin
      if (!v[i] && q[i].size() > 0 && $urandom_range(99) < pct) v[i] = 1;
      vv[i] = v[i];
      req_data[i*DW +: DW] = v[i] ? q[i][0] : 8'($urandom);
    end
    req_valid = vv; fifo_full = full_in;
    er = '0;
    if (m_busy && !full_in) er[m_last] = 1'b1;
    acc = m_busy && !full_in && vv[m_last];
    ed = acc ? q[m_last][0] : 8'h00;
    #4;
    tests++; if (req_ready !== er) begin fails++; $display("FAIL ready: got %b want %b", req_ready, er); end
    tests++; if (fifo_wr_en !== acc) begin fails++; $display("FAIL wr_en: got %b want %b", fifo_wr_en, acc); end
    tests++; if (fifo_wr_data !== ed) begin fails++; $display("FAIL wr_data: got %h want %h", fifo_wr_data, ed); end
    tests++; if (busy !== m_busy) begin fails++; $display("FAIL busy: got %b want %b", busy, m_busy); end
    tests++; if (grant_id !== 2'(m_last)) begin fails++; $display("FAIL grant_id: got %0d want %0d", grant_id, m_last); end
    tests++; if ($countones(req_ready) > 1) begin fails++; $display("FAIL onehot: got %b want at most one bit", req_ready); end
    wpat.push_back(fifo_wr_en); rpat.push_back(req_ready);
    if (fifo_wr_en) wlog.push_back(fifo_wr_data);
    if (busy && !prev_busy) glog.push_back(int'(grant_id));
    prev_busy = busy;
    if (acc) begin void'(q[m_last].pop_front()); v[m_last] = 0; end
    if (!m_busy) begin
      if (|vv) begin
        w = m_last;
        for (int k = 1; k <= N; k++) if (vv[(m_last + k) % N]) begin w = (m_last + k) % N; break; end
        m_last = w; m_budget = MB; m_busy = 1;
      end
    end else if (acc) begin
      m_budget--;
      if (m_budget == 0) m_busy = 0;
    end else if (!vv[m_last] && !full_in) m_busy = 0;
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    rst = 1; #1;
    tests++; if ({req_ready, fifo_wr_en, busy} !== '0) begin fails++; $display("FAIL reset_outs: got %b want 0", {req_ready, fifo_wr_en, busy}); end
    tests++; if (grant_id !== 2'(N - 1)) begin fails++; $display("FAIL reset_gid: got %0d want %0d", grant_id, N - 1); end
    tests++; if (fifo_wr_data !== '0) begin fails++; $display("FAIL reset_data: got %h want 0", fifo_wr_data); end
    do_reset();
  endtask
  task automatic test_single();
    bit ew [8];
    ew = '{0, 1, 1, 1, 1, 0, 1, 1};
    do_reset(); pct = 100;
    for (int i = 0; i < 6; i++) q[0].push_back(8'(8'h11 + i));
    for (int c = 0; c < 9; c++) cycle(0);
    for (int c = 0; c < 8; c++) begin
      tests++; if (wpat[c] !== ew[c]) begin fails++; $display("FAIL single_pat[%0d]: got %b want %b", c, wpat[c], ew[c]); end
    end
    tests++; if (wlog.size() != 6) begin fails++; $display("FAIL single_cnt: got %0d want 6", wlog.size()); end
    for (int i = 0; i < 6 && i < wlog.size(); i++) begin
      tests++; if (wlog[i] !== 8'(8'h11 + i)) begin fails++; $display("FAIL single_word[%0d]: got %h want %h", i, wlog[i], 8'h11 + i); end
    end
    tests++; if (glog.size() != 2 || glog[0] != 0 || glog[1] != 0) begin fails++; $display("FAIL single_grants: got %p want 0,0", glog); end
  endtask
  task automatic test_round_robin();
    int eg [5];
    eg = '{0, 1, 2, 3, 0};
    do_reset(); pct = 100;
    for (int i = 0; i < N; i++) for (int j = 0; j < 24; j++) q[i].push_back(8'($urandom));
    for (int c = 0; c < 25; c++) cycle(0);
    tests++; if (glog.size() != 5) begin fails++; $display("FAIL rr_cnt: got %0d want 5", glog.size()); end
    for (int i = 0; i < 5 && i < glog.size(); i++) begin
      tests++; if (glog[i] != eg[i]) begin fails++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, glog[i], eg[i]); end
    end
    for (int c = 0; c < 25; c++) begin
      tests++; if (wpat[c] !== (c % 5 != 0)) begin fails++; $display("FAIL rr_pat[%0d]: got %b want %b", c, wpat[c], c % 5 != 0); end
    end
  endtask
  task automatic test_full_stall();
    bit ew [9];
    ew = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
    do_reset(); pct = 100;
    for (int i = 0; i < 4; i++) q[2].push_back(8'(8'hA0 + i));
    for (int c = 0; c < 9; c++) cycle(c >= 3 && c <= 5);
    for (int c = 0; c < 9; c++) begin
      tests++; if (wpat[c] !== ew[c]) begin fails++; $display("FAIL stall_pat[%0d]: got %b want %b", c, wpat[c], ew[c]); end
    end
    for (int c = 3; c <= 5; c++) begin
      tests++; if (rpat[c] !== '0) begin fails++; $display("FAIL stall_ready[%0d]: got %b want 0", c, rpat[c]); end
    end
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      tests++; if (wlog[i] !== 8'(8'hA0 + i)) begin fails++; $display("FAIL stall_word[%0d]: got %h want %h", i, wlog[i], 8'hA0 + i); end
    end
    tests++; if (glog.size() != 1 || glog[0] != 2) begin fails++; $display("FAIL stall_grant: got %p want 2", glog); end
  endtask
  task automatic test_drop_valid();
    bit ew [8];
    ew = '{0, 1, 1, 0, 0, 1, 1, 0};
    do_reset(); pct = 100;
    q[1].push_back(8'h21); q[1].push_back(8'h22);
    q[3].push_back(8'h31); q[3].push_back(8'h32);
    for (int c = 0; c < 8; c++) cycle(0);
    for (int c = 0; c < 8; c++) begin
      tests++; if (wpat[c] !== ew[c]) begin fails++; $display("FAIL drop_pat[%0d]: got %b want %b", c, wpat[c], ew[c]); end
    end
    tests++; if (glog.size() != 2 || glog[0] != 1 || glog[1] != 3) begin fails++; $display("FAIL drop_grants: got %p want 1,3", glog); end
  endtask
  task automatic test_mid_reset();
    logic [7:0] first;
    do_reset(); pct = 100;
    for (int i = 0; i < N; i++) for (int j = 0; j < 10; j++) q[i].push_back(8'($urandom));
    for (int c = 0; c < 3; c++) cycle(0);
    #1; rst = 1; #1;
    tests++; if (req_ready !== '0) begin fails++; $display("FAIL mid_ready: got %b want 0", req_ready); end
    tests++; if (fifo_wr_en !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mid_wr_busy: got %b%b want 00", fifo_wr_en, busy); end
    @(posedge clk); #1; rst = 0;
    m_busy = 0; m_last = N - 1; clear_logs();
    first = q[0][0];
    for (int c = 0; c < 2; c++) cycle(0);
    tests++; if (glog.size() != 1 || glog[0] != 0) begin fails++; $display("FAIL mid_regrant: got %p want 0", glog); end
    tests++; if (wlog.size() != 1 || wlog[0] !== first) begin fails++; $display("FAIL mid_word: got %p want %h", wlog, first); end
  endtask
  task automatic test_random();
    int exp_seq [N];
    do_reset(); pct = 60;
    for (int i = 0; i < N; i++) begin
      exp_seq[i] = 0;
      for (int j = 0; j < 40; j++) q[i].push_back({2'(i), 6'(j)});
    end
    for (int c = 0; c < 400; c++) cycle($urandom_range(3) == 0);
    foreach (wlog[k]) begin
      tests++;
      if (int'(wlog[k][5:0]) != exp_seq[wlog[k][7:6]]) begin
        fails++; $display("FAIL rand_order: got seq %0d want %0d for req %0d", wlog[k][5:0], exp_seq[wlog[k][7:6]], wlog[k][7:6]);
      end
      exp_seq[wlog[k][7:6]]++;
    end
    tests++; if (wlog.size() < 100) begin fails++; $display("FAIL rand_volume: got %0d want >=100", wlog.size()); end
  endtask
`ifdef ARB_STATS_EN
  task automatic test_stats();
    int n = 0, cyc = 0;
    do_reset();
    tests++; if (stat_words !== '0) begin fails++; $display("FAIL stat_reset: got %h want 0", stat_words); end
    req_valid = 4'b0001;
    while (n < 70000 && cyc < 90000) begin
      #4; if (fifo_wr_en) n++;
      @(posedge clk); #1; cyc++;
    end
    req_valid = '0;
    tests++; if (n != 70000) begin fails++; $display("FAIL stat_budget: got %0d accepts want 70000", n); end
    tests++; if (stat_words[15:0] !== 16'hFFFF) begin fails++; $display("FAIL stat_sat: got %h want ffff", stat_words[15:0]); end
    tests++; if (stat_words[N*16-1:16] !== '0) begin fails++; $display("FAIL stat_others: got %h want 0", stat_words[N*16-1:16]); end
    stat_clr = 1; @(posedge clk); #1; stat_clr = 0;
    tests++; if (stat_words !== '0) begin fails++; $display("FAIL stat_clr: got %h want 0", stat_words); end
  endtask
`endif
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_drop_valid();
    test_mid_reset();
    test_random();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
